i2c_master_arbiter: RTL and testbench
=====================================

# i2c_master_arbiter

Shares one I2C master engine between two client FSMs (e.g. the BMP180 client and a second sensor client) on the same bus. Each client keeps its native master-facing handshake (start/send/receive/datasend in, isReady/sended/received/datareceive out); the arbiter grants the master to one client per transaction with round-robin fairness. It also enforces a quiet gap between owners and aborts a client that holds the bus too long.

## Interface
- `GUARD_CYCLES`, 4: idle cycles between release and next grant, range 1..255.
- `TIMEOUT_CYCLES`, 24'd1_000_000: maximum cycles one grant may last; 0 disables the watchdog.
- `clk`  in  1  system clock. One clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  client wants the master; held high for the whole transaction.
- `gnt0`, `gnt1`  out  1  client owns the master.
- `start0/1`, `send0/1`, `receive0/1`  in  1  client control toward the master.
- `datasend0/1`  in  8  client address/data byte.
- `isReady0/1`, `sended0/1`, `received0/1`  out  1  master status routed to the owner only.
- `datareceive0/1`  out  8  received byte routed to the owner only.
- `m_start`, `m_send`, `m_receive`  out  1  to the master.
- `m_datasend`  out  8  to the master.
- `m_isReady`, `m_sended`, `m_received`  in  1  from the master.
- `m_datareceive`  in  8  from the master.
- `timeout`  out  1  one-cycle pulse when the watchdog aborts a grant.
- `state`  out  2  current FSM state, for debug.

## Operation
- States: IDLE=0, OWNED=1, DRAIN=2, GUARD=3.
- IDLE:
  - The arbiter leaves IDLE only when at least one `req` is high and `m_isReady`=1.
  - Single requester: that requester is the winner.
  - Both requesters: the one that is not `last_owner` wins.
  - On exit, register `owner`, assert its `gnt`, clear `wd_cnt`, go to OWNED.
- OWNED:
  - Master-side outputs equal the owner's inputs.
  - The owner's status outputs equal the master's inputs.
  - The non-owner sees `isReady`/`sended`/`received`=0 and `datareceive`=0.
  - Owner's `req` low: go to DRAIN.
  - Watchdog: `wd_cnt` increments every OWNED cycle. If `TIMEOUT_CYCLES`≠0 and `wd_cnt`==`TIMEOUT_CYCLES`-1 while `req` is still high, pulse `timeout` and go to DRAIN.
  - `req` drop takes priority over timeout in the same cycle: no pulse.
- DRAIN:
  - `gnt` is low.
  - Master-side outputs are forced to 0 (start/send/receive low, datasend 8'h00).
  - Wait for `m_isReady`=1, then load `guard_cnt`=`GUARD_CYCLES`-1 and go to GUARD.
- GUARD:
  - Outputs stay forced to 0.
  - Decrement `guard_cnt`. At 0, set `last_owner`=`owner` and go to IDLE.
- The non-owner's `req` changing never affects the current grant.
- Reset, including mid-transaction:
  - All outputs 0, state IDLE.
  - `last_owner`=1, so requester 0 wins the first contention.
  - Counters cleared.

## Timing
- Grant latency: `gnt` rises 1 cycle after the IDLE cycle that sees `req`&`m_isReady`.
- Data path:
  - Routing between clients and master is combinational from registered `state`/`owner`: zero added latency.
  - The owner sees `isReady` in the same cycle `gnt` rises.
- Release: `gnt` falls 1 cycle after the owner's `req` falls.
- Minimum owner-to-owner gap: 1 (DRAIN) + `GUARD_CYCLES` + 1 (IDLE) cycles, with `m_isReady` already high.
- `timeout` is registered: high for exactly the first DRAIN cycle.
- Width rules:
  - `wd_cnt` is 24 bits and saturates; it never wraps.
  - `guard_cnt` is 8 bits.

## Structure
- Shared package `i2c_arb_pkg`:
  - state encodings (2-bit localparams);
  - `I2C_BYTE_W`=8;
  - `WD_W`=24;
  - `NULL_8`.
- Sub-module `i2c_arb_rr2`: combinational round-robin picker. Inputs `req0`, `req1`, `last_owner`; outputs `valid`, `winner`.
- The FSM, counters and routing muxes live in the top module.

## Test plan
- Single client: `req0`=1 with `m_isReady`=1 → `gnt0`=1 next cycle. `datasend0`=8'hEE appears on `m_datasend`; `m_sended` toggles echo on `sended0`; `sended1` stays 0.
- Contention after reset: `req0`=`req1`=1 in the same cycle → `gnt0` first. After `req0` drops, `gnt1` rises exactly 1+4+1+1 cycles later (`GUARD_CYCLES`=4).
- Fairness: both requests held continuously for 4 transactions → grants alternate 0,1,0,1.
- Drain wait: `req0` drops while `m_isReady`=0 for 20 cycles → state stays DRAIN 20 cycles, `m_start`/`m_send`/`m_receive`=0, no grant issued.
- Watchdog: `TIMEOUT_CYCLES`=100, `req1` held → `gnt1` drops after 100 cycles, `timeout` pulses once, `m_send` forced 0. Same-cycle `req` drop → no pulse.
- Async reset: assert `reset`=0 mid-OWNED → all outputs 0 immediately; after release, state=0 and `req0`/`req1` contention grants 0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared encodings and widths for the two-client I2C master arbiter.
// Combinational constants only: no latency, no backpressure.
package i2c_arb_pkg;

   localparam int I2C_BYTE_W = 8;
   localparam int WD_W       = 24;
   localparam int GUARD_W    = 8;

   localparam logic [I2C_BYTE_W-1:0] NULL_8 = 8'h00;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_OWNED = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_GUARD = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      OWNED = ST_OWNED,
      DRAIN = ST_DRAIN,
      GUARD = ST_GUARD
   } arbState_t;

endpackage

// File: rtl/i2c_arb_rr2.sv
// Two-way round-robin picker: on contention the client that did not own last wins.
// Purely combinational, zero latency; no backpressure of its own.
module i2c_arb_rr2 (
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic valid,
   output logic winner
);

   always_comb begin
      valid  = req0 | req1;
      winner = req1;
      if (req0 && req1) begin
         winner = ~last_owner;
      end
   end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Grants one shared I2C master to one of two clients per transaction, with a quiet gap and a watchdog.
// Grant 1 cycle after request; data routing is combinational; non-owners see idle status until granted.
module i2c_master_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned     GUARD_CYCLES   = 4,
   parameter logic [WD_W-1:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  req0,
   input  logic                  req1,
   output logic                  gnt0,
   output logic                  gnt1,

   input  logic                  start0,
   input  logic                  send0,
   input  logic                  receive0,
   input  logic [I2C_BYTE_W-1:0] datasend0,
   output logic                  isReady0,
   output logic                  sended0,
   output logic                  received0,
   output logic [I2C_BYTE_W-1:0] datareceive0,

   input  logic                  start1,
   input  logic                  send1,
   input  logic                  receive1,
   input  logic [I2C_BYTE_W-1:0] datasend1,
   output logic                  isReady1,
   output logic                  sended1,
   output logic                  received1,
   output logic [I2C_BYTE_W-1:0] datareceive1,

   output logic                  m_start,
   output logic                  m_send,
   output logic                  m_receive,
   output logic [I2C_BYTE_W-1:0] m_datasend,
   input  logic                  m_isReady,
   input  logic                  m_sended,
   input  logic                  m_received,
   input  logic [I2C_BYTE_W-1:0] m_datareceive,

   output logic                  timeout,
   output logic [1:0]            state
);

   localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);
   localparam logic [WD_W-1:0]    WD_LAST    = TIMEOUT_CYCLES - WD_W'(1);
   localparam logic [WD_W-1:0]    WD_MAX     = '1;

   arbState_t          curState, nextState;
   logic               owner, ownerNext;
   logic               lastOwner, lastOwnerNext;
   logic [WD_W-1:0]    wdCnt, wdCntNext;
   logic [GUARD_W-1:0] guardCnt, guardCntNext;
   logic               timeoutNext;

   logic pickValid, pickWinner;
   logic ownerReq;

   i2c_arb_rr2 uPicker (
      .req0       (req0),
      .req1       (req1),
      .last_owner (lastOwner),
      .valid      (pickValid),
      .winner     (pickWinner)
   );

   assign ownerReq = owner ? req1 : req0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         curState  <= IDLE;
         owner     <= 1'b0;
         lastOwner <= 1'b1;
         wdCnt     <= '0;
         guardCnt  <= '0;
         timeout   <= 1'b0;
      end else begin
         curState  <= nextState;
         owner     <= ownerNext;
         lastOwner <= lastOwnerNext;
         wdCnt     <= wdCntNext;
         guardCnt  <= guardCntNext;
         timeout   <= timeoutNext;
      end
   end

   always_comb begin
      nextState     = curState;
      ownerNext     = owner;
      lastOwnerNext = lastOwner;
      wdCntNext     = wdCnt;
      guardCntNext  = guardCnt;
      timeoutNext   = 1'b0;

      case (curState)
         IDLE: begin
            if (pickValid && m_isReady) begin
               ownerNext = pickWinner;
               wdCntNext = '0;
               nextState = OWNED;
            end
         end
         OWNED: begin
            if (wdCnt != WD_MAX) begin
               wdCntNext = wdCnt + WD_W'(1);
            end
            // A voluntary release in the same cycle beats the watchdog.
            if (!ownerReq) begin
               nextState = DRAIN;
            end else if ((TIMEOUT_CYCLES != '0) && (wdCnt == WD_LAST)) begin
               timeoutNext = 1'b1;
               nextState   = DRAIN;
            end
         end
         DRAIN: begin
            if (m_isReady) begin
               guardCntNext = GUARD_LOAD;
               nextState    = GUARD;
            end
         end
         GUARD: begin
            if (guardCnt == '0) begin
               lastOwnerNext = owner;
               nextState     = IDLE;
            end else begin
               guardCntNext = guardCnt - GUARD_W'(1);
            end
         end
         default: nextState = IDLE;
      endcase
   end

   logic owned, own0, own1;

   assign owned = (curState == OWNED);
   assign own0  = owned & ~owner;
   assign own1  = owned & owner;

   assign gnt0  = own0;
   assign gnt1  = own1;
   assign state = curState;

   // Outside OWNED everything toward the master is held at zero.
   always_comb begin
      m_start    = 1'b0;
      m_send     = 1'b0;
      m_receive  = 1'b0;
      m_datasend = NULL_8;
      if (own0) begin
         m_start    = start0;
         m_send     = send0;
         m_receive  = receive0;
         m_datasend = datasend0;
      end else if (own1) begin
         m_start    = start1;
         m_send     = send1;
         m_receive  = receive1;
         m_datasend = datasend1;
      end
   end

   assign isReady0     = own0 & m_isReady;
   assign sended0      = own0 & m_sended;
   assign received0    = own0 & m_received;
   assign datareceive0 = own0 ? m_datareceive : NULL_8;

   assign isReady1     = own1 & m_isReady;
   assign sended1      = own1 & m_sended;
   assign received1    = own1 & m_received;
   assign datareceive1 = own1 ? m_datareceive : NULL_8;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with a per-cycle behavioural model and literal spot checks.
module tb_i2c_master_arbiter;

   localparam int GUARD = 4;
   localparam int TO    = 100;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic req0 = 0, req1 = 0;
   logic gnt0, gnt1;
   logic start0 = 0, send0 = 0, receive0 = 0;
   logic [7:0] datasend0 = 8'h00;
   logic isReady0, sended0, received0;
   logic [7:0] datareceive0;
   logic start1 = 0, send1 = 0, receive1 = 0;
   logic [7:0] datasend1 = 8'h00;
   logic isReady1, sended1, received1;
   logic [7:0] datareceive1;
   logic m_start, m_send, m_receive;
   logic [7:0] m_datasend;
   logic m_isReady = 1'b1, m_sended = 0, m_received = 0;
   logic [7:0] m_datareceive = 8'h00;
   logic timeout;
   logic [1:0] state;

   int checks = 0;
   int failures = 0;

   i2c_master_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(24'd100)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
      .start0(start0), .send0(send0), .receive0(receive0), .datasend0(datasend0),
      .isReady0(isReady0), .sended0(sended0), .received0(received0), .datareceive0(datareceive0),
      .start1(start1), .send1(send1), .receive1(receive1), .datasend1(datasend1),
      .isReady1(isReady1), .sended1(sended1), .received1(received1), .datareceive1(datareceive1),
      .m_start(m_start), .m_send(m_send), .m_receive(m_receive), .m_datasend(m_datasend),
      .m_isReady(m_isReady), .m_sended(m_sended), .m_received(m_received),
      .m_datareceive(m_datareceive),
      .timeout(timeout), .state(state)
   );

   always #5 clk = ~clk;

   // Model: who holds the master, whether it is being released, remaining quiet cycles.
   int mOwner = -1;
   bit mRel = 1'b0;
   int mQuiet = 0;
   int mLast = 1;
   int mHeld = 0;
   bit mTo = 1'b0;

   function automatic logic reqOf(input int c);
      return (c == 0) ? req0 : req1;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mOwner <= -1; mRel <= 1'b0; mQuiet <= 0; mLast <= 1; mHeld <= 0; mTo <= 1'b0;
      end else begin
         mTo <= 1'b0;
         if (mOwner >= 0 && !mRel) begin
            mHeld <= mHeld + 1;
            if (!reqOf(mOwner)) begin
               mRel <= 1'b1;
            end else if (TO != 0 && mHeld + 1 == TO) begin
               mRel <= 1'b1;
               mTo  <= 1'b1;
            end
         end else if (mRel) begin
            if (m_isReady) begin
               mRel <= 1'b0; mLast <= mOwner; mOwner <= -1; mQuiet <= GUARD;
            end
         end else if (mQuiet > 0) begin
            mQuiet <= mQuiet - 1;
         end else if ((req0 || req1) && m_isReady) begin
            mOwner <= (req0 && req1) ? 1 - mLast : (req0 ? 0 : 1);
            mHeld  <= 0;
         end
      end
   end

   function automatic logic [37:0] expVec();
      logic o0, o1;
      logic [1:0] st;
      logic ms, md, mr;
      logic [7:0] mdat;
      o0 = (mOwner == 0) && !mRel;
      o1 = (mOwner == 1) && !mRel;
      st = (o0 || o1) ? 2'd1 : (mRel ? 2'd2 : ((mQuiet > 0) ? 2'd3 : 2'd0));
      ms = o0 ? start0 : (o1 ? start1 : 1'b0);
      md = o0 ? send0 : (o1 ? send1 : 1'b0);
      mr = o0 ? receive0 : (o1 ? receive1 : 1'b0);
      mdat = o0 ? datasend0 : (o1 ? datasend1 : 8'h00);
      return {o0, o1, mTo, st, ms, md, mr, mdat,
              o0 & m_isReady, o0 & m_sended, o0 & m_received, o0 ? m_datareceive : 8'h00,
              o1 & m_isReady, o1 & m_sended, o1 & m_received, o1 ? m_datareceive : 8'h00};
   endfunction

   function automatic logic [37:0] actVec();
      return {gnt0, gnt1, timeout, state, m_start, m_send, m_receive, m_datasend,
              isReady0, sended0, received0, datareceive0,
              isReady1, sended1, received1, datareceive1};
   endfunction

   int cyc = 0;
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         checks++;
         if (actVec() !== expVec()) begin
            failures++;
            $display("FAIL model_cycle cyc=%0d got=%h want=%h", cyc, actVec(), expVec());
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic waitGnt(input int c);
      int n = 0;
      while (!((c == 0) ? gnt0 : gnt1) && n < 60) begin
         tick(1);
         n++;
      end
      chk($sformatf("wait_gnt%0d", c), (c == 0) ? gnt0 : gnt1, 1);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (state != 2'd0 && n < 60) begin
         tick(1);
         n++;
      end
      chk("wait_idle", state, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n, cnt, tos;
      int seq [4];

      tick(2);
      reset = 1'b1;
      #1;
      chk("reset_state", state, 0);
      chk("reset_gnt", {gnt0, gnt1, timeout}, 0);

      // Single client routing.
      req0 = 1; send0 = 1; datasend0 = 8'hEE; datasend1 = 8'h55; m_datareceive = 8'hA5;
      tick(1);
      chk("t1_gnt0", {gnt0, gnt1}, 2'b10);
      chk("t1_m_datasend", m_datasend, 8'hEE);
      chk("t1_datareceive", {datareceive0, datareceive1}, 16'hA500);
      m_sended = 1; #1;
      chk("t1_sended_hi", {sended0, sended1}, 2'b10);
      tick(1); m_sended = 0; #1;
      chk("t1_sended_lo", {sended0, sended1}, 2'b00);
      req0 = 0; send0 = 0;
      tick(1);
      chk("t1_release", {gnt0, state}, 3'b0_10);
      waitIdle();

      // Contention right after reset: client 0 first, gap of 1+4+1+1 cycles.
      reset = 0; tick(1); reset = 1;
      req0 = 1; req1 = 1;
      tick(1);
      chk("t2_first_gnt", {gnt0, gnt1}, 2'b10);
      tick(3);
      req0 = 0;
      n = 0;
      while (!gnt1 && n < 40) begin
         tick(1);
         n++;
      end
      chk("t2_gap", n, 7);
      req1 = 0;
      tick(1);
      waitIdle();

      // Fairness with both clients re-requesting immediately.
      req0 = 1; req1 = 1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(gnt0 || gnt1) && n < 40) begin
            tick(1);
            n++;
         end
         seq[i] = gnt1 ? 1 : (gnt0 ? 0 : 9);
         tick(3);
         if (seq[i] == 0) req0 = 0; else req1 = 0;
         tick(1);
         req0 = 1; req1 = 1;
      end
      chk("t3_order", {seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0]}, 16'h0101);
      req0 = 0; req1 = 0;
      tick(1);
      waitIdle();

      // Drain stalls while the master is busy.
      req0 = 1;
      waitGnt(0);
      m_isReady = 0; start0 = 1; send0 = 1; receive0 = 1; req0 = 0; req1 = 1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (state == 2'd2 && !m_start && !m_send && !m_receive && !gnt0 && !gnt1) cnt++;
      end
      chk("t4_drain_hold", cnt, 20);
      m_isReady = 1; req1 = 0; start0 = 0; send0 = 0; receive0 = 0;
      tick(1);
      waitIdle();

      // Watchdog abort after 100 owned cycles.
      req1 = 1; send1 = 1;
      waitGnt(1);
      cnt = 0; tos = 0;
      while (gnt1 && cnt < 300) begin
         cnt++;
         if (timeout) tos++;
         tick(1);
      end
      chk("t5_wd_len", cnt, TO);
      chk("t5_wd_pulse", {tos[3:0], timeout, m_send}, 6'b0000_1_0);
      tick(1);
      chk("t5_pulse_once", timeout, 0);
      req1 = 0; send1 = 0;
      waitIdle();

      // Release in the last allowed cycle: no pulse.
      req1 = 1;
      waitGnt(1);
      tick(TO - 1);
      chk("t5b_still_owned", gnt1, 1);
      req1 = 0;
      tick(1);
      chk("t5b_no_pulse", {timeout, state}, 3'b0_10);
      waitIdle();

      // Asynchronous reset mid-transaction.
      req0 = 1;
      waitGnt(0);
      start0 = 1; send0 = 1; m_sended = 1; m_datareceive = 8'h3C;
      tick(1);
      reset = 0;
      #1;
      chk("t6_reset_outputs", actVec(), 0);
      start0 = 0; send0 = 0; m_sended = 0;
      tick(2);
      reset = 1; req1 = 1;
      #1;
      chk("t6_state_after", state, 0);
      tick(1);
      chk("t6_contention", {gnt0, gnt1}, 2'b10);
      req0 = 0; req1 = 0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
